// File: rtl/sync_rx.sv
// sync_rx: recovers pixel timing from async hs/vs; optional lock-loss counter via SYNC_RX_ERR_CNT_EN.
// Latency: sync edge to counter 3 clk, de/x/y/locked 1 clk after; free-running, no backpressure.
module sync_rx #(
  parameter int WIDTH  = 10,
  parameter int HSTART = 216,
  parameter int HACT   = 800,
  parameter int VSTART = 27,
  parameter int VACT   = 600
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hs_in,
  input  logic             vs_in,
  output logic [WIDTH+1:0] x,
  output logic [WIDTH+1:0] y,
  output logic             de,
  output logic             locked,
  output logic [WIDTH+1:0] h_total,
  output logic [WIDTH+1:0] v_total,
  output logic [7:0]       err_cnt
);

  localparam int CW = WIDTH + 2;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  localparam cnt_t H_LO = cnt_t'(HSTART);
  localparam cnt_t H_HI = cnt_t'(HSTART + HACT);
  localparam cnt_t V_LO = cnt_t'(VSTART);
  localparam cnt_t V_HI = cnt_t'(VSTART + VACT);

  logic   hs_s1_q, hs_s2_q, hs_dl_q, vs_s1_q, vs_s2_q, vs_dl_q;
  logic   hs_fall, vs_fall, h_sat;
  cnt_t   pos_h_q, pos_h_d, pos_v_q, pos_v_d;
  cnt_t   h_meas_q, h_meas_d, v_meas_q, v_meas_d, h_last_q, h_last_d;
  cnt_t   h_total_q, h_total_d, v_total_q, v_total_d;
  cnt_t   x_q, x_d, y_q, y_d, h_len, v_len, h_frame;
  logic   de_q, de_d, locked_q, locked_d;
  state_t state_q, state_d;

  always_comb begin
    hs_fall = hs_dl_q & ~hs_s2_q;
    vs_fall = vs_dl_q & ~vs_s2_q;
    h_len   = pos_h_q + 1'b1;
    v_len   = pos_v_q + 1'b1;
    h_sat   = (pos_h_q == '1) & ~hs_fall;

    pos_h_d = pos_h_q;
    if (hs_fall)             pos_h_d = '0;
    else if (pos_h_q != '1)  pos_h_d = h_len;

    pos_v_d = pos_v_q;
    if (vs_fall)                         pos_v_d = '0;
    else if (hs_fall && pos_v_q != '1)   pos_v_d = v_len;
  end

  always_comb begin
    state_d   = state_q;
    h_meas_d  = h_meas_q;
    v_meas_d  = v_meas_q;
    h_total_d = h_total_q;
    v_total_d = v_total_q;
    h_last_d  = hs_fall ? h_len : h_last_q;
    // Line length of the frame just ended: current line if it ends now, else the last one seen.
    h_frame   = hs_fall ? h_len : h_last_q;
    if (h_sat) begin
      state_d = SEARCH;
    end else begin
      case (state_q)
        SEARCH: if (vs_fall) state_d = MEASURE;
        MEASURE: begin
          if (hs_fall) h_meas_d = h_len;
          if (vs_fall) begin
            v_meas_d = v_len;
            state_d  = VERIFY;
          end
        end
        VERIFY: begin
          if (vs_fall) begin
            if (h_frame == h_meas_q && v_len == v_meas_q) begin
              state_d   = LOCKED;
              h_total_d = h_meas_q;
              v_total_d = v_meas_q;
            end else begin
              h_meas_d = h_frame;
              v_meas_d = v_len;
            end
          end
        end
        LOCKED: begin
          if ((hs_fall && h_len != h_total_q) || (vs_fall && v_len != v_total_q))
            state_d = MEASURE;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked_d = (state_q == LOCKED);
    de_d     = locked_q && (pos_h_q >= H_LO) && (pos_h_q < H_HI) &&
               (pos_v_q >= V_LO) && (pos_v_q < V_HI);
    x_d      = de_d ? (pos_h_q - H_LO) : '0;
    y_d      = de_d ? (pos_v_q - V_LO) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_s1_q   <= 1'b1;
      hs_s2_q   <= 1'b1;
      hs_dl_q   <= 1'b1;
      vs_s1_q   <= 1'b1;
      vs_s2_q   <= 1'b1;
      vs_dl_q   <= 1'b1;
      pos_h_q   <= '0;
      pos_v_q   <= '0;
      h_meas_q  <= '0;
      v_meas_q  <= '0;
      h_last_q  <= '0;
      h_total_q <= '0;
      v_total_q <= '0;
      state_q   <= SEARCH;
      locked_q  <= 1'b0;
      de_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      hs_s1_q   <= hs_in;
      hs_s2_q   <= hs_s1_q;
      hs_dl_q   <= hs_s2_q;
      vs_s1_q   <= vs_in;
      vs_s2_q   <= vs_s1_q;
      vs_dl_q   <= vs_s2_q;
      pos_h_q   <= pos_h_d;
      pos_v_q   <= pos_v_d;
      h_meas_q  <= h_meas_d;
      v_meas_q  <= v_meas_d;
      h_last_q  <= h_last_d;
      h_total_q <= h_total_d;
      v_total_q <= v_total_d;
      state_q   <= state_d;
      locked_q  <= locked_d;
      de_q      <= de_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign de      = de_q;
  assign locked  = locked_q;
  assign h_total = h_total_q;
  assign v_total = v_total_q;

`ifdef SYNC_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       lock_loss;

  // Every exit from LOCKED outside reset is a lock-loss event.
  always_comb begin
    lock_loss = (state_q == LOCKED) && (state_d != LOCKED);
    err_cnt_d = err_cnt_q;
    if (lock_loss && err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'h00;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_sync_rx.sv
// Bench for sync_rx: directed sync sources, pixel scoreboard fed by the stimulus, monitor on de.
module tb_sync_rx;

  localparam int HS = 8, HA = 24, VS = 2, VA = 8;
  localparam int LLEN = 40, NLINES = 12, HSL = 4, VSL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic [11:0] x, y, h_total, v_total;
  logic        de, locked;
  logic [7:0]  err_cnt;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } pix_t;

  pix_t sb[$];
  pix_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   loss_cnt = 0;

  sync_rx #(.WIDTH(10), .HSTART(HS), .HACT(HA), .VSTART(VS), .VACT(VA)) dut (
    .clk(clk), .rst(rst), .hs_in(hs_in), .vs_in(vs_in),
    .x(x), .y(y), .de(de), .locked(locked),
    .h_total(h_total), .v_total(v_total), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_err();
`ifdef SYNC_RX_ERR_CNT_EN
    return (loss_cnt > 255) ? 255 : loss_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_de"}, int'(de), 0);
    check({tag, "_x"}, int'(x), 0);
    check({tag, "_y"}, int'(y), 0);
    check({tag, "_h_total"}, int'(h_total), 0);
    check({tag, "_v_total"}, int'(v_total), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  // One frame of sync; hs and vs fall together at the start of the frame.
  task automatic run_frame(input int nlines, input int llen, input int hsl, input int vsl,
                           input int short_line, input int short_len, input bit exp_pix,
                           input int rst_line);
    int len;
    if (exp_pix) begin
      for (int v = VS; v < VS + VA; v++) begin
        int hmax;
        if (short_line >= 0 && v > short_line) break;
        hmax = (v == short_line) ? short_len - 1 : llen - 1;
        for (int h = HS; h < HS + HA && h <= hmax; h++)
          sb.push_back('{x: 12'(h - HS), y: 12'(v - VS)});
      end
    end
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? short_len : llen;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if (l == rst_line && c == 21) check_all_zero("mid_reset");
        hs_in = (c >= hsl);
        vs_in = (l >= vsl);
        rst   = (l == rst_line && c == 20);
      end
    end
  endtask

  task automatic nominal_frame(input bit exp_pix);
    run_frame(NLINES, LLEN, HSL, VSL, -1, 0, exp_pix, -1);
  endtask

  task automatic small_frame(input int nlines);
    run_frame(nlines, 8, 2, 1, -1, 0, 1'b0, -1);
  endtask

  always @(negedge clk) begin
    if (de) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL pixel_unexpected: got de=1 x=%0d y=%0d, expected no pixel", x, y);
      end else begin
        mon_e = sb.pop_front();
        if (x != mon_e.x || y != mon_e.y) begin
          fails++;
          $display("FAIL pixel: got x=%0d y=%0d, expected x=%0d y=%0d", x, y, mon_e.x, mon_e.y);
        end
      end
    end else begin
      tests++;
      if (x != 12'd0 || y != 12'd0) begin
        fails++;
        $display("FAIL blank_xy: got x=%0d y=%0d, expected 0 0", x, y);
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Nominal lock on the third vs_fall
    nominal_frame(1'b0);
    check("lock_after_vs1", int'(locked), 0);
    nominal_frame(1'b0);
    check("lock_after_vs2", int'(locked), 0);
    nominal_frame(1'b1);
    check("lock_after_vs3", int'(locked), 1);
    check("h_total", int'(h_total), LLEN);
    check("v_total", int'(v_total), NLINES);
    check("sb_empty_f2", sb.size(), 0);
    nominal_frame(1'b1);

    // Short line while locked
    run_frame(NLINES, LLEN, HSL, VSL, 5, 30, 1'b1, -1);
    loss_cnt++;
    check("glitch_locked", int'(locked), 0);
    check("glitch_err_cnt", int'(err_cnt), exp_err());
    check("sb_empty_glitch", sb.size(), 0);
    nominal_frame(1'b0);
    check("glitch_verify_locked", int'(locked), 0);
    nominal_frame(1'b1);
    check("glitch_relocked", int'(locked), 1);
    check("glitch_h_total", int'(h_total), LLEN);

    // Sync absent long enough for pos_h to saturate
    repeat (4200) begin
      @(negedge clk);
      hs_in = 1'b1;
      vs_in = 1'b1;
    end
    loss_cnt++;
    check("loss_locked", int'(locked), 0);
    check("loss_err_cnt", int'(err_cnt), exp_err());
    nominal_frame(1'b0);
    nominal_frame(1'b0);
    check("loss_not_locked_vs2", int'(locked), 0);
    nominal_frame(1'b1);
    check("loss_relocked_vs3", int'(locked), 1);

    // Reset mid-frame while locked
    run_frame(NLINES, LLEN, HSL, VSL, -1, 0, 1'b1, 11);
    loss_cnt = 0;
    nominal_frame(1'b0);
    nominal_frame(1'b0);
    check("rst_not_locked_vs2", int'(locked), 0);
    nominal_frame(1'b1);
    check("rst_relocked_vs3", int'(locked), 1);
    check("rst_err_cnt", int'(err_cnt), 0);

    // Repeated lock losses on a tiny 8x3 raster
    small_frame(3);
    loss_cnt++;
    small_frame(3);
    for (int i = 0; i < 299; i++) begin
      small_frame(2);
      loss_cnt++;
      small_frame(3);
      small_frame(3);
      if (i == 9) check("err_cnt_mid", int'(err_cnt), exp_err());
    end
    small_frame(3);
    check("sat_locked", int'(locked), 1);
    check("sat_err_cnt", int'(err_cnt), exp_err());
    check("sat_h_total", int'(h_total), 8);
    check("sat_v_total", int'(v_total), 3);
    check("sb_empty_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
